// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared constants and helpers for the LED PWM sequencer
package led_ctrl_pkg;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_DUTY_R  = 3'd1;
    localparam logic [2:0] ADDR_DUTY_G  = 3'd2;
    localparam logic [2:0] ADDR_DUTY_B  = 3'd3;
    localparam logic [2:0] ADDR_DUTY_IR = 3'd4;
    localparam logic [2:0] ADDR_MODE    = 3'd5;
    localparam logic [2:0] ADDR_RATE    = 3'd6;
    localparam logic [2:0] ADDR_STATUS  = 3'd7;

    localparam int NUM_CH     = 4;
    localparam int BLINK_MULT = 16;

    typedef enum logic [1:0] {
        MODE_STATIC     = 2'b00,
        MODE_BLINK      = 2'b01,
        MODE_BREATHE    = 2'b10,
        MODE_STATIC_ALT = 2'b11
    } led_mode_e;

    typedef enum logic {
        ENV_UP   = 1'b0,
        ENV_DOWN = 1'b1
    } env_dir_e;

    // Breathe scaling: 8x8 product truncated to its upper byte.
    function automatic logic [7:0] scale_duty(input logic [7:0] duty, input logic [7:0] env);
        logic [15:0] prod;
        prod = {8'h00, duty} * {8'h00, env};
        return prod[15:8];
    endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// rtl/led_pwm_chan.sv - one PWM channel with static/blink/breathe duty selection
module led_pwm_chan
    import led_ctrl_pkg::*;
#(
    parameter int FRAME_BITS = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [FRAME_BITS-1:0] cnt_i,
    input  logic [7:0]            duty_i,
    input  logic [1:0]            mode_i,
    input  logic                  phase_on_i,
    input  logic [7:0]            env_i,
    input  logic                  en_i,
    output logic                  pwm_o
);

    localparam int CW = (FRAME_BITS > 8) ? FRAME_BITS : 8;

    logic [7:0] eff_duty;
    logic       phase_ok;
    logic       pwm_d;
    logic       pwm_q;

    always_comb begin
        eff_duty = duty_i;
        phase_ok = 1'b1;
        case (led_mode_e'(mode_i))
            MODE_BLINK:   phase_ok = phase_on_i;
            MODE_BREATHE: eff_duty = scale_duty(duty_i, env_i);
            default:      ;
        endcase
        pwm_d = en_i && phase_ok && (CW'(cnt_i) < CW'(eff_duty));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - register-programmable RGB/IR PWM sequencer with blink and breathe
module led_pwm_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int PRESCALE   = 47,
    parameter int FRAME_BITS = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] reg_addr,
    input  logic [7:0] reg_wdata,
    input  logic       reg_wr,
    input  logic       reg_rd,
    output logic [7:0] reg_rdata,
    output logic       reg_ack,
    output logic       red_o,
    output logic       green_o,
    output logic       blue_o,
    output logic       ir_o
);

    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    logic                   en_q;
    logic                   en_d;
    logic [NUM_CH-1:0][7:0] duty_q;
    logic [NUM_CH-1:0][7:0] duty_sh_q;
    logic [7:0]             mode_q;
    logic [7:0]             mode_sh_q;
    logic [7:0]             rate_q;
    logic [PW-1:0]          pre_q;
    logic [FRAME_BITS-1:0]  cnt_q;
    logic [11:0]            fcnt_q;
    logic [7:0]             scnt_q;
    logic [7:0]             env_q;
    env_dir_e               dir_q;
    logic                   phase_q;
    logic                   run_q;
    logic [7:0]             rdata_q;
    logic                   ack_q;
    logic [7:0]             rd_val;
    logic                   active;
    logic                   tick;
    logic                   frame_start;
    logic [11:0]            blink_lim;
    logic [NUM_CH-1:0]      pwm;

    assign en_d        = (reg_wr && (reg_addr == ADDR_CTRL)) ? reg_wdata[0] : en_q;
    assign active      = en_q && en_d;
    assign tick        = (pre_q == PW'(PRESCALE));
    assign frame_start = tick && (&cnt_q);
    assign blink_lim   = ({4'h0, rate_q} + 12'd1) * 12'(BLINK_MULT) - 12'd1;

    always_comb begin
        rd_val = 8'h00;
        case (reg_addr)
            ADDR_CTRL:    rd_val = {7'b0, en_q};
            ADDR_DUTY_R:  rd_val = duty_q[0];
            ADDR_DUTY_G:  rd_val = duty_q[1];
            ADDR_DUTY_B:  rd_val = duty_q[2];
            ADDR_DUTY_IR: rd_val = duty_q[3];
            ADDR_MODE:    rd_val = mode_q;
            ADDR_RATE:    rd_val = rate_q;
            default:      rd_val = {6'b0, dir_q, phase_q};
        endcase
    end

    // Read data is sampled before the write commits, so a combined strobe returns the old value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_q    <= 1'b0;
            duty_q  <= '0;
            mode_q  <= 8'h00;
            rate_q  <= 8'h00;
            rdata_q <= 8'h00;
            ack_q   <= 1'b0;
        end else begin
            ack_q   <= reg_wr || reg_rd;
            rdata_q <= reg_rd ? rd_val : 8'h00;
            en_q    <= en_d;
            if (reg_wr) begin
                case (reg_addr)
                    ADDR_DUTY_R:  duty_q[0] <= reg_wdata;
                    ADDR_DUTY_G:  duty_q[1] <= reg_wdata;
                    ADDR_DUTY_B:  duty_q[2] <= reg_wdata;
                    ADDR_DUTY_IR: duty_q[3] <= reg_wdata;
                    ADDR_MODE:    mode_q    <= reg_wdata;
                    ADDR_RATE:    rate_q    <= reg_wdata;
                    default:      ;
                endcase
            end
        end
    end

    // Phase bit 0 means lit. The first frame start only loads shadows; effects advance from the second.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q     <= '0;
            cnt_q     <= '0;
            fcnt_q    <= '0;
            scnt_q    <= '0;
            env_q     <= '0;
            dir_q     <= ENV_UP;
            phase_q   <= 1'b0;
            run_q     <= 1'b0;
            duty_sh_q <= '0;
            mode_sh_q <= '0;
        end else if (!active) begin
            pre_q     <= '0;
            cnt_q     <= '0;
            fcnt_q    <= '0;
            scnt_q    <= '0;
            env_q     <= '0;
            dir_q     <= ENV_UP;
            phase_q   <= 1'b0;
            run_q     <= 1'b0;
            duty_sh_q <= '0;
            mode_sh_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                cnt_q <= cnt_q + FRAME_BITS'(1);
            end
            if (frame_start) begin
                duty_sh_q <= duty_q;
                mode_sh_q <= mode_q;
                run_q     <= 1'b1;
                if (run_q) begin
                    if (fcnt_q >= blink_lim) begin
                        fcnt_q  <= '0;
                        phase_q <= ~phase_q;
                    end else begin
                        fcnt_q <= fcnt_q + 12'd1;
                    end
                    if (scnt_q >= rate_q) begin
                        scnt_q <= '0;
                        if (dir_q == ENV_UP) begin
                            if (env_q == 8'hFF) begin
                                dir_q <= ENV_DOWN;
                                env_q <= 8'hFE;
                            end else begin
                                env_q <= env_q + 8'd1;
                            end
                        end else begin
                            if (env_q == 8'h00) begin
                                dir_q <= ENV_UP;
                                env_q <= 8'h01;
                            end else begin
                                env_q <= env_q - 8'd1;
                            end
                        end
                    end else begin
                        scnt_q <= scnt_q + 8'd1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        led_pwm_chan #(
            .FRAME_BITS(FRAME_BITS)
        ) u_chan (
            .clk        (clk),
            .resetn     (resetn),
            .cnt_i      (cnt_q),
            .duty_i     (duty_sh_q[g]),
            .mode_i     (mode_sh_q[2*g +: 2]),
            .phase_on_i (~phase_q),
            .env_i      (env_q),
            .en_i       (en_d),
            .pwm_o      (pwm[g])
        );
    end

    assign reg_rdata = rdata_q;
    assign reg_ack   = ack_q;
    assign red_o     = pwm[0];
    assign green_o   = pwm[1];
    assign blue_o    = pwm[2];
    assign ir_o      = pwm[3];

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb/tb_led_pwm_ctrl.sv - self-checking bench for led_pwm_ctrl with a frame-level model
module tb_led_pwm_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] reg_addr = 3'd0;
    logic [7:0] reg_wdata = 8'h00;
    logic       reg_wr = 1'b0;
    logic       reg_rd = 1'b0;
    logic [7:0] reg_rdata;
    logic       reg_ack;
    logic       red_o, green_o, blue_o, ir_o;

    int checks = 0;
    int failures = 0;

    led_pwm_ctrl #(.PRESCALE(0), .FRAME_BITS(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .red_o     (red_o),
        .green_o   (green_o),
        .blue_o    (blue_o),
        .ir_o      (ir_o)
    );

    always #5 clk = ~clk;

    // Frame-level model: n = ticks since enable, frame index and position follow arithmetically.
    bit       m_en = 0;
    int       m_reg[8];
    int       s_duty[4];
    int       s_mode = 0;
    int       s_rate = 0;
    int       n = 0;
    bit [3:0] e_out = '0;
    bit       e_ack = 0;
    int       e_rdata = 0;
    int       out_fi = -1;
    int       out_cnt = 0;
    bit       chk_on = 0;
    int       fc[4];

    function automatic int env_of(int f, int rate);
        int s, p;
        s = f / (rate + 1);
        p = s % 510;
        return (p <= 255) ? p : 510 - p;
    endfunction

    function automatic int dir_of(int f, int rate);
        int s, p;
        s = f / (rate + 1);
        p = s % 510;
        return ((p >= 256) || (p == 0 && s > 0)) ? 1 : 0;
    endfunction

    function automatic int off_of(int f, int rate);
        return ((f / ((rate + 1) * 16)) % 2);
    endfunction

    function automatic int model_read(int a, int f);
        if (a == 0) return int'(m_en);
        if (a == 7) return (m_en && f >= 0) ? (dir_of(f, s_rate) * 2 + off_of(f, s_rate)) : 0;
        return m_reg[a];
    endfunction

    always @(posedge clk) begin
        int  fi, c, md, eff;
        bit  en_nx, act, lit;
        if (!resetn) begin
            m_en = 0;
            foreach (m_reg[i]) m_reg[i] = 0;
            foreach (s_duty[i]) s_duty[i] = 0;
            s_mode = 0; s_rate = 0; n = 0;
            e_out = '0; e_ack = 0; e_rdata = 0; out_fi = -1; out_cnt = 0;
        end else begin
            en_nx = (reg_wr && reg_addr == 3'd0) ? reg_wdata[0] : m_en;
            act = m_en && en_nx;
            fi = n / 256 - 1;
            c = n % 256;
            for (int ch = 0; ch < 4; ch++) begin
                md  = (s_mode >> (2 * ch)) & 3;
                lit = (md == 1) ? (off_of(fi, s_rate) == 0) : 1'b1;
                eff = (md == 2) ? ((s_duty[ch] * env_of(fi, s_rate)) >> 8) : s_duty[ch];
                e_out[ch] = act && (fi >= 0) && lit && (c < eff);
            end
            e_ack = reg_wr || reg_rd;
            e_rdata = reg_rd ? model_read(int'(reg_addr), fi) : 0;
            out_fi = act ? fi : -1;
            out_cnt = c;
            if (act && c == 255) begin
                for (int ch = 0; ch < 4; ch++) s_duty[ch] = m_reg[ch + 1];
                s_mode = m_reg[5];
                s_rate = m_reg[6];
            end
            if (reg_wr && reg_addr >= 3'd1 && reg_addr <= 3'd6) m_reg[reg_addr] = int'(reg_wdata);
            m_en = en_nx;
            if (act) begin
                n++;
            end else begin
                n = 0;
                foreach (s_duty[i]) s_duty[i] = 0;
                s_mode = 0; s_rate = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("red_o", int'(red_o), int'(resetn && e_out[0]));
            chk("green_o", int'(green_o), int'(resetn && e_out[1]));
            chk("blue_o", int'(blue_o), int'(resetn && e_out[2]));
            chk("ir_o", int'(ir_o), int'(resetn && e_out[3]));
            chk("reg_ack", int'(reg_ack), int'(resetn && e_ack));
            if (resetn && e_ack) chk("reg_rdata", int'(reg_rdata), e_rdata);
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
        @(negedge clk);
        reg_wr = 1'b0;
        chk("wr_ack", int'(reg_ack), 1);
    endtask

    task automatic rd(input logic [2:0] a, output int q);
        reg_addr = a; reg_rd = 1'b1;
        @(negedge clk);
        reg_rd = 1'b0;
        chk("rd_ack", int'(reg_ack), 1);
        q = int'(reg_rdata);
    endtask

    task automatic wait_pos(input int f, input int c);
        int guard;
        guard = 0;
        while (!(out_fi == f && out_cnt == c) && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100000) begin
            checks++;
            failures++;
            $display("FAIL wait_pos timeout: frame %0d pos %0d never reached", f, c);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    endtask

    task automatic count_frame(input int f);
        wait_pos(f, 0);
        foreach (fc[i]) fc[i] = 0;
        for (int i = 0; i < 256; i++) begin
            fc[0] += int'(red_o);
            fc[1] += int'(green_o);
            fc[2] += int'(blue_o);
            fc[3] += int'(ir_o);
            if (i < 255) @(negedge clk);
        end
    endtask

    initial begin
        int v, z, g, k;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_on = 1;
        chk("rst_outputs", int'({red_o, green_o, blue_o, ir_o}), 0);
        chk("rst_ack", int'(reg_ack), 0);
        chk("rst_rdata", int'(reg_rdata), 0);
        resetn = 1'b1;

        wr(3'd0, 8'h01);
        wr(3'd1, 8'd64);
        count_frame(1);
        chk("red_duty64", fc[0], 64);
        chk("green_duty0", fc[1], 0);
        chk("blue_idle", fc[2], 0);
        chk("ir_idle", fc[3], 0);

        reg_addr = 3'd1; reg_wdata = 8'h80; reg_wr = 1'b1; reg_rd = 1'b1;
        @(negedge clk);
        reg_wr = 1'b0; reg_rd = 1'b0;
        chk("rw_ack", int'(reg_ack), 1);
        chk("rw_old_data", int'(reg_rdata), 8'h40);
        rd(3'd1, v);
        chk("rd_after_rw", v, 8'h80);

        wait_pos(3, 100);
        wr(3'd2, 8'd255);
        z = 0; g = 0;
        while (out_fi == 3 && g < 300) begin
            z += int'(green_o);
            g++;
            @(negedge clk);
        end
        chk("green_midframe_hold", z, 0);
        count_frame(4);
        chk("green_duty255", fc[1], 255);
        chk("red_duty128", fc[0], 128);

        wr(3'd0, 8'h00);
        wr(3'd5, 8'h90);
        wr(3'd6, 8'h00);
        wr(3'd3, 8'd128);
        wr(3'd4, 8'd255);
        wr(3'd0, 8'h01);
        count_frame(0);
        chk("blink_on_f0", fc[2], 128);
        chk("breathe_f0", fc[3], 0);
        count_frame(2);
        chk("breathe_f2", fc[3], 1);
        count_frame(16);
        chk("blink_off_f16", fc[2], 0);
        wait_pos(20, 50);
        rd(3'd7, v);
        chk("status_f20", v, 1);
        count_frame(32);
        chk("blink_on_f32", fc[2], 128);
        count_frame(100);
        chk("breathe_f100", fc[3], 99);
        wait_pos(254, 50);
        rd(3'd7, v);
        chk("status_f254", v, 1);
        count_frame(255);
        chk("breathe_peak", fc[3], 254);
        wait_pos(256, 50);
        rd(3'd7, v);
        chk("status_f256_down", v, 2);
        count_frame(257);
        chk("breathe_f257", fc[3], 252);

        wr(3'd5, 8'h00);
        wr(3'd1, 8'd255);
        wr(3'd2, 8'd255);
        wr(3'd3, 8'd255);
        wr(3'd4, 8'd255);
        k = out_fi;
        wait_pos(k + 2, 100);
        chk("all_on_before_disable", int'({red_o, green_o, blue_o, ir_o}), 15);
        wr(3'd0, 8'h00);
        chk("disable_outputs_low", int'({red_o, green_o, blue_o, ir_o}), 0);
        rd(3'd7, v);
        chk("status_after_disable", v, 0);
        wr(3'd0, 8'h01);
        wait_pos(1, 10);
        chk("regs_retained_red", int'(red_o), 1);

        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_outputs", int'({red_o, green_o, blue_o, ir_o}), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        rd(3'd1, v);
        chk("duty_r_after_reset", v, 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
